// File: rtl/tpu_seq_pkg.sv
// Shared types and sizing helpers for the systolic tile sequencer.
package tpu_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WREAD,
    ST_WLOAD,
    ST_STREAM,
    ST_DRAIN,
    ST_FIN
  } tpu_seq_state_t;

  localparam int DEF_MATRIX_SIZE = 8;

  // Result alignment latency of an N x N array: skew in + skew out + 2 register stages.
  function automatic int res_lat_default(input int matrix_size);
    return 2 * matrix_size + 2;
  endfunction

  // Row counts run 1..2^addr_w, so one extra bit is needed.
  function automatic int rows_width(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/tpu_valid_pipe.sv
// Validity-only delay line: one token per UB read, emerging DEPTH cycles later.
module tpu_valid_pipe #(
  parameter int DEPTH = 17
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic in_valid,
  output logic out_valid,
  output logic empty
);

  logic [DEPTH-1:0] vld_q, vld_d;

  always_comb begin
    vld_d    = '0;
    vld_d[0] = in_valid;
    for (int k = 1; k < DEPTH; k++) vld_d[k] = vld_q[k-1];
    // Flush also drops the token arriving this cycle.
    if (flush) vld_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_q <= '0;
    else     vld_q <= vld_d;
  end

  assign out_valid = vld_q[DEPTH-1];
  assign empty     = ~|vld_q;

endmodule

// File: rtl/tpu_tile_sequencer.sv
// Command-driven sequencer: optional weight reload, N UB row reads, and
// results SRAM writes aligned RES_LAT cycles after each read.
module tpu_tile_sequencer
  import tpu_seq_pkg::*;
#(
  parameter int MATRIX_SIZE   = DEF_MATRIX_SIZE,
  parameter int ADDRESSSIZE   = 10,
  parameter int ADDRESSSIZE_W = 2,
  parameter int RES_LAT       = res_lat_default(MATRIX_SIZE)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_reload,
  input  logic [ADDRESSSIZE_W-1:0] cmd_w_addr,
  input  logic [ADDRESSSIZE-1:0]   cmd_src_addr,
  input  logic [ADDRESSSIZE-1:0]   cmd_dst_addr,
  input  logic [ADDRESSSIZE:0]     cmd_rows,
  input  logic                     abort,
  output logic [ADDRESSSIZE_W-1:0] wb_rd_addr,
  output logic                     we_rl,
  output logic                     ub_rd_en,
  output logic [ADDRESSSIZE-1:0]   ub_rd_addr,
  output logic                     res_wr_en,
  output logic [ADDRESSSIZE-1:0]   res_wr_addr,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int RW = rows_width(ADDRESSSIZE);
  // One extra cycle comes from the registered res_wr_en output.
  localparam int PIPE_DEPTH = RES_LAT - 1;

  tpu_seq_state_t state_q, state_d;

  logic [ADDRESSSIZE_W-1:0] w_addr_q, w_addr_d;
  logic [ADDRESSSIZE-1:0]   src_q, src_d, dst_q, dst_d, wcnt_q, wcnt_d;
  logic [RW-1:0]            rows_q, rows_d, rcnt_q, rcnt_d;

  logic [ADDRESSSIZE_W-1:0] wb_rd_addr_q, wb_rd_addr_d;
  logic                     we_rl_q, we_rl_d;
  logic                     ub_rd_en_q, ub_rd_en_d;
  logic [ADDRESSSIZE-1:0]   ub_rd_addr_q, ub_rd_addr_d;
  logic                     res_wr_en_q, res_wr_en_d;
  logic [ADDRESSSIZE-1:0]   res_wr_addr_q, res_wr_addr_d;
  logic                     busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic accept, active, flush, last_read, pipe_out, pipe_empty;

  assign cmd_ready = (state_q == ST_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign active    = state_q inside {ST_WREAD, ST_WLOAD, ST_STREAM, ST_DRAIN};
  assign flush     = abort && active;
  assign last_read = (rcnt_q == rows_q - RW'(1));

  tpu_valid_pipe #(.DEPTH(PIPE_DEPTH)) u_pipe (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (ub_rd_en_q),
    .out_valid(pipe_out),
    .empty    (pipe_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (cmd_rows == '0)  state_d = ST_FIN;
          else if (cmd_reload) state_d = ST_WREAD;
          else                 state_d = ST_STREAM;
        end
      end
      ST_WREAD:  state_d = ST_WLOAD;
      ST_WLOAD:  state_d = ST_STREAM;
      ST_STREAM: if (last_read) state_d = ST_DRAIN;
      ST_DRAIN:  if (pipe_empty) state_d = ST_FIN;
      ST_FIN:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_FIN;
  end

  // Command latches and read/write indices.
  always_comb begin
    w_addr_d = accept ? cmd_w_addr   : w_addr_q;
    src_d    = accept ? cmd_src_addr : src_q;
    dst_d    = accept ? cmd_dst_addr : dst_q;
    rows_d   = accept ? cmd_rows     : rows_q;
    rcnt_d   = (state_q == ST_STREAM && state_d == ST_STREAM) ? rcnt_q + RW'(1) : '0;
    wcnt_d   = wcnt_q;
    if (accept)                wcnt_d = '0;
    else if (pipe_out && !flush) wcnt_d = wcnt_q + ADDRESSSIZE'(1);
  end

  // Outputs are registered, so they are derived from the state being entered.
  always_comb begin
    wb_rd_addr_d  = (state_d == ST_WREAD) ? w_addr_d : '0;
    we_rl_d       = (state_d == ST_WLOAD);
    ub_rd_en_d    = (state_d == ST_STREAM);
    ub_rd_addr_d  = ub_rd_en_d ? src_d + rcnt_d[ADDRESSSIZE-1:0] : '0;
    res_wr_en_d   = pipe_out && !flush;
    res_wr_addr_d = res_wr_en_d ? dst_q + wcnt_q : '0;
    busy_d        = (state_d != ST_IDLE);
    done_d        = (state_d == ST_FIN);
    err_d         = done_d && (flush || state_q == ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_addr_q      <= '0;
      src_q         <= '0;
      dst_q         <= '0;
      rows_q        <= '0;
      rcnt_q        <= '0;
      wcnt_q        <= '0;
      wb_rd_addr_q  <= '0;
      we_rl_q       <= 1'b0;
      ub_rd_en_q    <= 1'b0;
      ub_rd_addr_q  <= '0;
      res_wr_en_q   <= 1'b0;
      res_wr_addr_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      w_addr_q      <= w_addr_d;
      src_q         <= src_d;
      dst_q         <= dst_d;
      rows_q        <= rows_d;
      rcnt_q        <= rcnt_d;
      wcnt_q        <= wcnt_d;
      wb_rd_addr_q  <= wb_rd_addr_d;
      we_rl_q       <= we_rl_d;
      ub_rd_en_q    <= ub_rd_en_d;
      ub_rd_addr_q  <= ub_rd_addr_d;
      res_wr_en_q   <= res_wr_en_d;
      res_wr_addr_q <= res_wr_addr_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  assign wb_rd_addr  = wb_rd_addr_q;
  assign we_rl       = we_rl_q;
  assign ub_rd_en    = ub_rd_en_q;
  assign ub_rd_addr  = ub_rd_addr_q;
  assign res_wr_en   = res_wr_en_q;
  assign res_wr_addr = res_wr_addr_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_tpu_tile_sequencer.sv
// Bench for tpu_tile_sequencer: per-cycle schedule model plus directed literal checks.
module tb_tpu_tile_sequencer;

  localparam int MS    = 8;
  localparam int AW    = 10;
  localparam int AWW   = 2;
  localparam int RL    = 2 * MS + 2;
  localparam int AMASK = (1 << AW) - 1;
  localparam int BIG   = 32'h7fffffff;

  logic clk = 1'b0;
  logic rst;
  logic cmd_valid, cmd_ready, cmd_reload, abort;
  logic [AWW-1:0] cmd_w_addr;
  logic [AW-1:0]  cmd_src_addr, cmd_dst_addr;
  logic [AW:0]    cmd_rows;
  logic [AWW-1:0] wb_rd_addr;
  logic we_rl, ub_rd_en, res_wr_en, busy, done, err;
  logic [AW-1:0]  ub_rd_addr, res_wr_addr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tpu_tile_sequencer #(
    .MATRIX_SIZE(MS), .ADDRESSSIZE(AW), .ADDRESSSIZE_W(AWW), .RES_LAT(RL)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_reload(cmd_reload),
    .cmd_w_addr(cmd_w_addr), .cmd_src_addr(cmd_src_addr), .cmd_dst_addr(cmd_dst_addr),
    .cmd_rows(cmd_rows), .abort(abort),
    .wb_rd_addr(wb_rd_addr), .we_rl(we_rl), .ub_rd_en(ub_rd_en), .ub_rd_addr(ub_rd_addr),
    .res_wr_en(res_wr_en), .res_wr_addr(res_wr_addr),
    .busy(busy), .done(done), .err(err)
  );

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    total++;
    bad++;
    $display("FAIL %s: got=timeout want=event t=%0t", nm, $time);
  endtask

  // Model: the most recent command, described by its acceptance cycle and fields.
  bit has_cmd = 0;
  bit mrl;
  int ma, mn, mab, msrc, mdst, mw;
  int ncyc = 0;

  initial begin
    forever begin
      int c, first, dc;
      bit e_busy, e_ready, e_done, e_err, e_we, e_wbv, e_rd, e_wr;
      int e_wb, e_rda, e_wra;
      @(negedge clk);
      ncyc++;
      c = ncyc;
      e_busy = 0; e_ready = 1; e_done = 0; e_err = 0; e_we = 0; e_wbv = 0;
      e_rd = 0; e_wr = 0; e_wb = 0; e_rda = 0; e_wra = 0; dc = BIG;
      if (rst) has_cmd = 0;
      if (has_cmd) begin
        first = ma + (mrl ? 3 : 1);
        if (mn == 0)         dc = ma + 1;
        else if (mab != BIG) dc = mab + 1;
        else                 dc = first + mn - 1 + RL + 1;
        e_busy  = (c > ma) && (c <= dc);
        e_ready = !e_busy;
        e_done  = (c == dc);
        e_err   = e_done && (mn == 0 || mab != BIG);
        if (mn > 0 && c <= mab) begin
          if (mrl && c == ma + 1) begin e_wbv = 1; e_wb = mw; end
          if (mrl && c == ma + 2) e_we = 1;
          if (c >= first && c < first + mn) begin
            e_rd = 1; e_rda = (msrc + c - first) & AMASK;
          end
          if (c >= first + RL && c < first + RL + mn) begin
            e_wr = 1; e_wra = (mdst + c - first - RL) & AMASK;
          end
        end
      end
      chk("cmd_ready", int'(cmd_ready), int'(e_ready));
      chk("busy", int'(busy), int'(e_busy));
      chk("done", int'(done), int'(e_done));
      chk("err", int'(err), int'(e_err));
      chk("we_rl", int'(we_rl), int'(e_we));
      chk("ub_rd_en", int'(ub_rd_en), int'(e_rd));
      chk("res_wr_en", int'(res_wr_en), int'(e_wr));
      if (e_wbv) chk("wb_rd_addr", int'(wb_rd_addr), e_wb);
      if (e_rd)  chk("ub_rd_addr", int'(ub_rd_addr), e_rda);
      if (e_wr)  chk("res_wr_addr", int'(res_wr_addr), e_wra);
      if (!rst) begin
        if (has_cmd && abort && c > ma && c < dc) mab = c;
        if (cmd_valid && e_ready) begin
          has_cmd = 1; ma = c; mab = BIG;
          mrl = cmd_reload; mw = int'(cmd_w_addr);
          msrc = int'(cmd_src_addr); mdst = int'(cmd_dst_addr); mn = int'(cmd_rows);
        end
      end
    end
  end

  // Trace of one command, relative to its acceptance cycle (k=0).
  int rdq[$], rdk[$], wrq[$], wrk[$];
  int we_k, done_k, wb1;
  bit err_v, rdy_done, rdy_next;

  function automatic int q_at(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic accept_cmd(input bit rl, input int w, input int src, input int dst,
                            input int rows, input bit ab0);
    int t;
    @(posedge clk); #1;
    cmd_valid = 1; cmd_reload = rl; abort = ab0;
    cmd_w_addr = w[AWW-1:0]; cmd_src_addr = src[AW-1:0];
    cmd_dst_addr = dst[AW-1:0]; cmd_rows = rows[AW:0];
    @(negedge clk);
    t = 0;
    while (!cmd_ready && t < 200) begin @(negedge clk); t++; end
    if (!cmd_ready) fail_now("accept_wait");
  endtask

  task automatic trace(input int ab_k);
    int k;
    rdq.delete(); rdk.delete(); wrq.delete(); wrk.delete();
    we_k = -1; done_k = -1; wb1 = -1; err_v = 0; rdy_done = 0; rdy_next = 0;
    k = 0;
    while (done_k < 0 && k < 400) begin
      @(posedge clk); #1;
      cmd_valid = 0; k++;
      abort = (k == ab_k);
      @(negedge clk);
      if (k == 1) wb1 = int'(wb_rd_addr);
      if (we_rl) we_k = k;
      if (ub_rd_en)  begin rdq.push_back(int'(ub_rd_addr));  rdk.push_back(k); end
      if (res_wr_en) begin wrq.push_back(int'(res_wr_addr)); wrk.push_back(k); end
      if (done) begin done_k = k; err_v = err; rdy_done = cmd_ready; end
    end
    @(posedge clk); #1;
    abort = 0;
    @(negedge clk);
    rdy_next = cmd_ready;
    if (done_k < 0) fail_now("done_wait");
  endtask

  task automatic run_cmd(input bit rl, input int w, input int src, input int dst,
                         input int rows, input int ab_k, input bit ab0);
    accept_cmd(rl, w, src, dst, rows, ab0);
    trace(ab_k);
  endtask

  initial begin
    #1_000_000;
    fail_now("watchdog");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int d1, acc2, k;
    rst = 1; cmd_valid = 0; cmd_reload = 0; abort = 0;
    cmd_w_addr = '0; cmd_src_addr = '0; cmd_dst_addr = '0; cmd_rows = '0;
    repeat (3) @(posedge clk);
    #1 rst = 0;

    // Reload, 4 rows.
    run_cmd(1, 2, 'h010, 'h100, 4, 0, 0);
    chk("t1_wb_addr", wb1, 2);
    chk("t1_we_cycle", we_k, 2);
    chk("t1_nrd", rdq.size(), 4);
    chk("t1_rd0_cycle", q_at(rdk, 0), 3);
    chk("t1_rd0_addr", q_at(rdq, 0), 'h010);
    chk("t1_rd3_addr", q_at(rdq, 3), 'h013);
    chk("t1_nwr", wrq.size(), 4);
    chk("t1_wr0_cycle", q_at(wrk, 0), 21);
    chk("t1_wr3_cycle", q_at(wrk, 3), 24);
    chk("t1_wr0_addr", q_at(wrq, 0), 'h100);
    chk("t1_wr3_addr", q_at(wrq, 3), 'h103);
    chk("t1_done_cycle", done_k, 25);
    chk("t1_err", int'(err_v), 0);

    // Address wrap-around.
    run_cmd(0, 0, 'h3FE, 'h3FF, 3, 0, 0);
    chk("t2_rd0_cycle", q_at(rdk, 0), 1);
    chk("t2_rd0", q_at(rdq, 0), 'h3FE);
    chk("t2_rd1", q_at(rdq, 1), 'h3FF);
    chk("t2_rd2", q_at(rdq, 2), 'h000);
    chk("t2_wr0", q_at(wrq, 0), 'h3FF);
    chk("t2_wr1", q_at(wrq, 1), 'h000);
    chk("t2_wr2", q_at(wrq, 2), 'h001);

    // Zero rows.
    run_cmd(1, 1, 'h5, 'h6, 0, 0, 0);
    chk("t3_nrd", rdq.size(), 0);
    chk("t3_nwr", wrq.size(), 0);
    chk("t3_done_cycle", done_k, 1);
    chk("t3_err", int'(err_v), 1);

    // Abort in the 3rd streaming cycle.
    run_cmd(0, 0, 'h040, 'h080, 8, 3, 0);
    chk("t4_nrd", rdq.size(), 3);
    chk("t4_nwr", wrq.size(), 0);
    chk("t4_done_cycle", done_k, 4);
    chk("t4_err", int'(err_v), 1);
    chk("t4_ready_at_done", int'(rdy_done), 0);
    chk("t4_ready_after", int'(rdy_next), 1);

    // Asynchronous reset while draining.
    accept_cmd(0, 0, 'h020, 'h040, 2, 0);
    for (int i = 1; i <= 10; i++) begin @(posedge clk); #1; cmd_valid = 0; end
    #1 rst = 1;
    #1;
    chk("t5_busy", int'(busy), 0);
    chk("t5_ub_rd_en", int'(ub_rd_en), 0);
    chk("t5_res_wr_en", int'(res_wr_en), 0);
    chk("t5_done", int'(done), 0);
    chk("t5_ready", int'(cmd_ready), 1);
    @(posedge clk); @(posedge clk); #1 rst = 0;
    run_cmd(0, 0, 'h055, 'h066, 1, 0, 0);
    chk("t5_nwr", wrq.size(), 1);
    chk("t5_wr0", q_at(wrq, 0), 'h066);

    // Back-to-back with cmd_valid held.
    accept_cmd(0, 0, 'h100, 'h200, 2, 0);
    d1 = -1; acc2 = -1; k = 0;
    while (acc2 < 0 && k < 200) begin
      @(posedge clk); #1;
      if (k == 0) begin cmd_src_addr = 'h300; cmd_dst_addr = 'h3FE; cmd_rows = 3; end
      k++;
      @(negedge clk);
      if (done) d1 = k;
      if (cmd_ready) acc2 = k;
    end
    if (acc2 < 0) fail_now("t6_accept2");
    trace(0);
    chk("t6_done1", d1, 21);
    chk("t6_accept2", acc2, 22);
    chk("t6_nwr2", wrq.size(), 3);
    chk("t6_wr2_last", q_at(wrq, 2), 'h000);

    // Randomized commands, aborts and idle noise; the per-cycle model checks everything.
    for (int n = 0; n < 40; n++) begin
      int r, rows, abk;
      bit rl, ab0;
      rl   = 1'($urandom_range(0, 1));
      r    = $urandom_range(0, 9);
      rows = (r == 0) ? 0 : (r < 8) ? $urandom_range(1, 6) : $urandom_range(7, 40);
      abk  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, rows + RL + 4) : 0;
      ab0  = ($urandom_range(0, 7) == 0);
      run_cmd(rl, $urandom_range(0, 3), $urandom_range(0, AMASK), $urandom_range(0, AMASK),
              rows, abk, ab0);
      if (abk == 0) chk("rnd_nwr", wrq.size(), rows);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
        abort = 1'($urandom_range(0, 1));
      end
      abort = 0;
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
